// File: rtl/bambu_slave_pkg.sv
// Shared types and constants for the Bambu slave-port initiator.
// Op codes, FSM states and channel-0 slicing constants.
package bambu_slave_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_RUN     = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StRun,
        StResp
    } state_e;

    // Access size field carries the size in bits; only byte accesses are issued.
    localparam int unsigned SIZE_BYTE = 8;

    // Only channel 0 of the core slave port is ever driven.
    localparam int unsigned CH0 = 0;

endpackage

// File: rtl/bambu_slave_port_master_if.sv
// Command/response stream plus the Bambu core slave-memory port and start/done pair.
// The master modport is the initiator side; slave is the sequencer/core side.
interface bambu_slave_port_master_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SIZE_W = 4,
    parameter int unsigned CNT_W  = 32
) ();

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_op;
    logic [ADDR_W-1:0]        cmd_addr;
    logic [DATA_W-1:0]        cmd_wdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic [CNT_W-1:0]         rsp_cycles;
    logic                     rsp_err;

    logic [N_CH-1:0]          S_oe_ram;
    logic [N_CH-1:0]          S_we_ram;
    logic [N_CH*ADDR_W-1:0]   S_addr_ram;
    logic [N_CH*DATA_W-1:0]   S_Wdata_ram;
    logic [N_CH*SIZE_W-1:0]   S_data_ram_size;
    logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram;
    logic [N_CH-1:0]          Sout_DataRdy;

    logic                     start_port;
    logic                     done_port;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  Sout_Rdata_ram, Sout_DataRdy, done_port,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_cycles, rsp_err,
        output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output Sout_Rdata_ram, Sout_DataRdy, done_port,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_cycles, rsp_err,
        input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port
    );

endinterface

// File: rtl/bambu_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Clear together with enable restarts the count at 1.
module bambu_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d, base;

    always_comb begin
        base    = clr ? '0 : count_q;
        count_d = base;
        if (en && (base != '1)) begin
            count_d = base + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/bambu_slave_port_master.sv
// Initiator for the slave memory port of a Bambu HLS core: byte writes/reads into
// core memories and a start/done run with cycle count, driven by a cmd/rsp stream.
module bambu_slave_port_master
    import bambu_slave_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SIZE_W  = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input logic                       clock,
    input logic                       reset,
    bambu_slave_port_master_if.master bus
);

    state_e             state_q, state_d;
    op_e                op_q;

    logic               cmd_hs, rdy0, issue_entry, resp_exit;
    logic               to_clr, to_en, run_clr, run_en;
    logic [CNT_W-1:0]   to_count, run_count;
    logic [DATA_W-1:0]  cap_rdata;

    logic               rsp_load, rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_d;
    logic [CNT_W-1:0]   rsp_cycles_d;

    logic               cmd_ready_q, oe_q, we_q, start_q;
    logic               rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic [CNT_W-1:0]   rsp_cycles_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [SIZE_W-1:0]  size_q;

    logic               unused_in;

    assign cmd_hs      = bus.cmd_valid & cmd_ready_q;
    assign rdy0        = bus.Sout_DataRdy[CH0];
    assign cap_rdata   = (op_q == OP_READ) ? bus.Sout_Rdata_ram[CH0*DATA_W +: DATA_W] : '0;
    assign issue_entry = (state_q == StIdle) && (state_d == StIssue);
    assign resp_exit   = (state_q == StResp) && (state_d == StIdle);

    bambu_sat_counter #(
        .CNT_W (CNT_W)
    ) u_timeout_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (to_clr),
        .en    (to_en),
        .count (to_count)
    );

    bambu_sat_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (run_clr),
        .en    (run_en),
        .count (run_count)
    );

    always_comb begin
        state_d      = state_q;
        to_clr       = 1'b0;
        to_en        = 1'b0;
        run_clr      = 1'b0;
        run_en       = 1'b0;
        rsp_load     = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;
        rsp_cycles_d = '0;
        case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    case (op_e'(bus.cmd_op))
                        OP_WRITE, OP_READ: state_d = StIssue;
                        OP_RUN: begin
                            // Clear+enable lands the run count at 1 in the start cycle.
                            state_d = StRun;
                            run_clr = 1'b1;
                            run_en  = 1'b1;
                        end
                        default: begin
                            state_d   = StResp;
                            rsp_load  = 1'b1;
                            rsp_err_d = 1'b1;
                        end
                    endcase
                end
            end
            StIssue: begin
                to_clr = 1'b1;
                if (rdy0) begin
                    state_d     = StResp;
                    rsp_load    = 1'b1;
                    rsp_rdata_d = cap_rdata;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                to_en = 1'b1;
                if (rdy0) begin
                    state_d     = StResp;
                    rsp_load    = 1'b1;
                    rsp_rdata_d = cap_rdata;
                end else if (to_count == CNT_W'(TIMEOUT - 2)) begin
                    // Count reaches TIMEOUT-1 on this edge: give up.
                    state_d   = StResp;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                end
            end
            StRun: begin
                if (bus.done_port) begin
                    state_d      = StResp;
                    rsp_load     = 1'b1;
                    rsp_cycles_d = run_count;
                end else begin
                    run_en = 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OP_WRITE;
        end else begin
            state_q <= state_d;
            if (cmd_hs) begin
                op_q <= op_e'(bus.cmd_op);
            end
        end
    end

    // Outputs are registered from next-state so they change only on clock edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_ready_q  <= 1'b0;
            oe_q         <= 1'b0;
            we_q         <= 1'b0;
            start_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_cycles_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
        end else begin
            cmd_ready_q <= (state_d == StIdle);
            oe_q        <= issue_entry && (bus.cmd_op == OP_READ);
            we_q        <= issue_entry && (bus.cmd_op == OP_WRITE);
            start_q     <= (state_q == StIdle) && (state_d == StRun);
            rsp_valid_q <= (state_d == StResp);

            if (issue_entry) begin
                addr_q  <= bus.cmd_addr;
                wdata_q <= (bus.cmd_op == OP_WRITE) ? bus.cmd_wdata : '0;
                size_q  <= SIZE_W'(SIZE_BYTE);
            end else if ((state_d != StIssue) && (state_d != StWait)) begin
                addr_q  <= '0;
                wdata_q <= '0;
                size_q  <= '0;
            end

            if (rsp_load) begin
                rsp_err_q    <= rsp_err_d;
                rsp_rdata_q  <= rsp_rdata_d;
                rsp_cycles_q <= rsp_cycles_d;
            end else if (resp_exit) begin
                rsp_err_q    <= 1'b0;
                rsp_rdata_q  <= '0;
                rsp_cycles_q <= '0;
            end
        end
    end

    assign bus.cmd_ready       = cmd_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rsp_rdata_q;
    assign bus.rsp_cycles      = rsp_cycles_q;
    assign bus.rsp_err         = rsp_err_q;
    assign bus.start_port      = start_q;
    assign bus.S_oe_ram        = N_CH'(oe_q);
    assign bus.S_we_ram        = N_CH'(we_q);
    assign bus.S_addr_ram      = (N_CH*ADDR_W)'(addr_q);
    assign bus.S_Wdata_ram     = (N_CH*DATA_W)'(wdata_q);
    assign bus.S_data_ram_size = (N_CH*SIZE_W)'(size_q);

    // Other channels' read data and ready are deliberately ignored.
    assign unused_in = ^{bus.Sout_Rdata_ram, bus.Sout_DataRdy};

endmodule

// File: tb/tb_bambu_slave_port_master.sv
// Directed bench for bambu_slave_port_master: vector table plus hand sequences for
// response back-pressure and asynchronous reset during WAIT and RUN.
module tb_bambu_slave_port_master;
    import bambu_slave_pkg::*;

    localparam int unsigned N_CH = 2, ADDR_W = 7, DATA_W = 8, SIZE_W = 4;
    localparam int unsigned TIMEOUT = 64, CNT_W = 32;
    localparam int NV = 10;

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [7:0]  wd;
        int          rdy_lat;
        int          done_lat;
        logic [7:0]  e_rdata;
        logic [31:0] e_cyc;
        logic        e_err;
        int          e_n;
        int          e_oe;
        int          e_we;
        int          e_st;
    } vec_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   rdy_lat_g;
    int   done_lat_g;
    logic [7:0] mem [128];
    vec_t vecs [NV];

    bambu_slave_port_master_if #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W),
        .CNT_W  (CNT_W)
    ) bus ();

    bambu_slave_port_master #(
        .N_CH    (N_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SIZE_W  (SIZE_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_cycles, bus.rsp_err,
                 bus.S_oe_ram, bus.S_we_ram, bus.S_addr_ram, bus.S_Wdata_ram,
                 bus.S_data_ram_size, bus.start_port};
    endfunction

    // Core-side responder: byte memory with programmable DataRdy latency and done delay.
    initial begin
        int rcnt;
        int dcnt;
        rcnt = 0;
        dcnt = 0;
        for (int a = 0; a < 128; a++) mem[a] = 8'h00;
        bus.Sout_DataRdy   = 2'b10;
        bus.Sout_Rdata_ram = 16'hFF00;
        bus.done_port      = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bus.Sout_DataRdy[0] = 1'b0;
            bus.done_port       = 1'b0;
            if (reset) begin
                rcnt = 0;
                dcnt = 0;
            end else begin
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) bus.Sout_DataRdy[0] = 1'b1;
                end
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) bus.done_port = 1'b1;
                end
                if (bus.S_we_ram[0]) mem[bus.S_addr_ram[6:0]] = bus.S_Wdata_ram[7:0];
                if (bus.S_we_ram[0] || bus.S_oe_ram[0]) begin
                    bus.Sout_Rdata_ram[7:0] = mem[bus.S_addr_ram[6:0]];
                    if (rdy_lat_g == 0) bus.Sout_DataRdy[0] = 1'b1;
                    else if (rdy_lat_g > 0) rcnt = rdy_lat_g;
                end
                if (bus.start_port) begin
                    if (done_lat_g == 0) bus.done_port = 1'b1;
                    else if (done_lat_g > 0) dcnt = done_lat_g;
                end
            end
        end
    end

    // Called #1 after a rising edge; returns at the same phase.
    task automatic run_vec(input int i, input string tag);
        vec_t v;
        logic accepted, got, hi;
        int n, oe_n, we_n, st_n;
        logic [6:0] sa;
        logic [3:0] ss;
        logic [7:0] sw;
        v = vecs[i];
        rdy_lat_g = v.rdy_lat;
        done_lat_g = v.done_lat;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wd;
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clock);
            accepted = bus.cmd_ready;
            @(posedge clock);
            #1;
        end
        bus.cmd_valid = 1'b0;
        chk({tag, "_accept"}, 64'(accepted), 64'd1);
        if (accepted) begin
            got = 1'b0; hi = 1'b0;
            n = 0; oe_n = 0; we_n = 0; st_n = 0;
            sa = '0; ss = '0; sw = '0;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clock);
                n++;
                if (bus.S_oe_ram[0]) oe_n++;
                if (bus.S_we_ram[0]) we_n++;
                if (bus.start_port) st_n++;
                if (bus.S_oe_ram[0] || bus.S_we_ram[0]) begin
                    sa = bus.S_addr_ram[6:0];
                    ss = bus.S_data_ram_size[3:0];
                    sw = bus.S_Wdata_ram[7:0];
                end
                if (bus.S_oe_ram[1] || bus.S_we_ram[1] || (|bus.S_addr_ram[13:7]) ||
                    (|bus.S_Wdata_ram[15:8]) || (|bus.S_data_ram_size[7:4])) hi = 1'b1;
                if (bus.rsp_valid) got = 1'b1;
            end
            chk({tag, "_rsp_seen"}, 64'(got), 64'd1);
            if (got) begin
                chk({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(v.e_rdata));
                chk({tag, "_cycles"}, 64'(bus.rsp_cycles), 64'(v.e_cyc));
                chk({tag, "_err"}, 64'(bus.rsp_err), 64'(v.e_err));
                chk({tag, "_latency"}, 64'(n), 64'(v.e_n));
                chk({tag, "_oe_pulses"}, 64'(oe_n), 64'(v.e_oe));
                chk({tag, "_we_pulses"}, 64'(we_n), 64'(v.e_we));
                chk({tag, "_start_pulses"}, 64'(st_n), 64'(v.e_st));
                chk({tag, "_other_ch_zero"}, 64'(hi), 64'd0);
                chk({tag, "_cmd_ready_low"}, 64'(bus.cmd_ready), 64'd0);
                if (v.op == 2'd0 || v.op == 2'd1) begin
                    chk({tag, "_bus_addr"}, 64'(sa), 64'(v.addr));
                    chk({tag, "_bus_size"}, 64'(ss), 64'd8);
                    chk({tag, "_bus_wdata"}, 64'(sw), (v.op == 2'd0) ? 64'(v.wd) : 64'd0);
                end
                bus.rsp_ready = 1'b1;
                @(posedge clock);
                #1;
                bus.rsp_ready = 1'b0;
            end
        end
    endtask

    initial begin
        int seen;
        logic ok;
        //            op    addr   wd     rl  dl   rdata  cyc    err   n   oe we st
        vecs[0] = '{2'd0, 7'h05, 8'hA7,  1, -1, 8'h00, 32'd0,  1'b0,  3, 0, 1, 0};
        vecs[1] = '{2'd1, 7'h05, 8'h00,  2, -1, 8'hA7, 32'd0,  1'b0,  4, 1, 0, 0};
        vecs[2] = '{2'd2, 7'h00, 8'h00, -1, 10, 8'h00, 32'd11, 1'b0, 12, 0, 0, 1};
        vecs[3] = '{2'd1, 7'h10, 8'h00, -1, -1, 8'h00, 32'd0,  1'b1, 65, 1, 0, 0};
        vecs[4] = '{2'd0, 7'h7F, 8'h3C,  0, -1, 8'h00, 32'd0,  1'b0,  2, 0, 1, 0};
        vecs[5] = '{2'd1, 7'h7F, 8'h00,  0, -1, 8'h3C, 32'd0,  1'b0,  2, 1, 0, 0};
        vecs[6] = '{2'd2, 7'h00, 8'h00, -1,  0, 8'h00, 32'd1,  1'b0,  2, 0, 0, 1};
        vecs[7] = '{2'd2, 7'h00, 8'h00, -1,  1, 8'h00, 32'd2,  1'b0,  3, 0, 0, 1};
        vecs[8] = '{2'd3, 7'h05, 8'h55, -1, -1, 8'h00, 32'd0,  1'b1,  1, 0, 0, 0};
        vecs[9] = '{2'd1, 7'h05, 8'h00,  1, -1, 8'hA7, 32'd0,  1'b0,  3, 1, 0, 0};

        n_checks = 0;
        n_errors = 0;
        rdy_lat_g = -1;
        done_lat_g = -1;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("reset_outputs_async", 64'(any_out()), 64'd0);
        repeat (3) @(negedge clock);
        chk("reset_outputs_held", 64'(any_out()), 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < NV; i++) run_vec(i, $sformatf("v%0d", i));

        // Illegal op with the response held off for five cycles.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd3;
        bus.cmd_addr  = 7'h22;
        bus.cmd_wdata = 8'h99;
        @(negedge clock);
        chk("ill_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("ill_hold%0d", k),
                64'({bus.rsp_valid, bus.rsp_err, bus.cmd_ready, bus.rsp_rdata, bus.rsp_cycles,
                     bus.S_oe_ram, bus.S_we_ram}),
                64'({1'b1, 1'b1, 1'b0, 8'h00, 32'd0, 2'b00, 2'b00}));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        chk("ill_after_ack", 64'({bus.rsp_valid, bus.cmd_ready}), 64'b01);
        @(posedge clock);
        #1;

        // Reset while a read waits forever for DataRdy.
        rdy_lat_g = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_addr  = 7'h11;
        @(negedge clock);
        chk("rstw_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rstw_outputs_zero", 64'(any_out()), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (bus.rsp_valid) seen++;
        end
        chk("rstw_no_response", 64'(seen), 64'd0);
        chk("rstw_idle_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clock);
        #1;

        // Reset while the core is running and never finishes.
        done_lat_g = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        @(negedge clock);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        ok = bus.start_port;
        chk("rstr_start_seen", 64'(ok), 64'd1);
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("rstr_outputs_zero", 64'(any_out()), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.rsp_valid || bus.start_port) seen++;
        end
        chk("rstr_no_response", 64'(seen), 64'd0);
        chk("rstr_idle_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clock);
        #1;

        // Normal traffic resumes after both resets.
        run_vec(1, "post_rst_read");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bambu_slave_port_master.md
Name: bambu_slave_port_master

Overview:
- Hardware initiator for the slave memory port of a Bambu-generated `main` core.
- Loads input bytes into core-internal memories, starts the core, counts cycles until `done_port`, then reads results back.
- Turns a simple command/response stream into `S_oe_ram`/`S_we_ram` transactions and tracks `Sout_DataRdy`.
- Sits between an on-chip test sequencer (or host bridge) and the HLS core; replaces the tied-off slave signals used in pure simulation.

Parameters:
- N_CH, 2, number of slave channels on the core port; only channel 0 is driven, the others are held at 0.
- ADDR_W, 7, address bits per channel (core bus `S_addr_ram` is N_CH*ADDR_W).
- DATA_W, 8, data bits per channel.
- SIZE_W, 4, size-field bits per channel; holds the access size in bits.
- TIMEOUT, 64, maximum cycles to wait for `Sout_DataRdy[0]` after issue.
- CNT_W, 32, width of the run-cycle counter.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_op  in  2  0=write, 1=read, 2=run; 3 is illegal.
- cmd_addr  in  ADDR_W  byte address for write/read.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  DATA_W  read data; 0 for write, run and illegal responses.
- rsp_cycles  out  CNT_W  run cycle count; 0 for write/read.
- rsp_err  out  1  timeout or illegal op.
- S_oe_ram  out  N_CH  read strobe per channel.
- S_we_ram  out  N_CH  write strobe per channel.
- S_addr_ram  out  N_CH*ADDR_W  address per channel.
- S_Wdata_ram  out  N_CH*DATA_W  write data per channel.
- S_data_ram_size  out  N_CH*SIZE_W  access size per channel.
- Sout_Rdata_ram  in  N_CH*DATA_W  read data from the core.
- Sout_DataRdy  in  N_CH  per-channel completion.
- start_port  out  1  core start pulse.
- done_port  in  1  core completion.

Behaviour:
- Reset: every output is 0; FSM in IDLE; counters cleared. Reset asserted mid-transaction aborts the transaction without producing a response.
- FSM states: IDLE, ISSUE, WAIT, RUN, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake, register op/addr/wdata, then go to ISSUE for write/read, RUN for run, or RESP with rsp_err=1 for op 3.
- ISSUE (exactly 1 cycle):
  - Drive S_oe_ram[0] (read) or S_we_ram[0] (write) high.
  - Drive S_addr_ram[ADDR_W-1:0]=addr and S_data_ram_size[SIZE_W-1:0]=8.
  - For writes, drive S_Wdata_ram[DATA_W-1:0]=wdata.
  - Go to WAIT with the timeout counter at 0.
- WAIT:
  - Strobes low; address, data and size are held stable.
  - When Sout_DataRdy[0]=1 in the same cycle as the ISSUE strobe, the event is captured and WAIT is skipped straight to RESP.
  - On Sout_DataRdy[0]=1, capture Sout_Rdata_ram[DATA_W-1:0] for reads (0 for writes) and go to RESP with rsp_err=0.
  - If the counter reaches TIMEOUT-1 without DataRdy, go to RESP with rsp_err=1 and rsp_rdata=0.
- RUN:
  - start_port=1 for exactly the first RUN cycle; the cycle counter starts at 1 in that cycle.
  - The counter increments every cycle until done_port is sampled 1; the cycle in which done_port=1 is included in the count.
  - Result: a done_port in the cycle after the start_port pulse gives rsp_cycles=2.
  - No timeout in RUN; the counter saturates at all-ones.
  - done_port sampled high in the start cycle counts as done, giving rsp_cycles=1.
- RESP:
  - rsp_valid=1; response fields are stable until the handshake.
  - On rsp_ready, return to IDLE; the next command can be accepted the following cycle.
  - cmd_ready=0 in every state except IDLE.
- Sout_DataRdy[0] arriving outside WAIT or ISSUE, and any activity on other channels, is ignored.
- All outputs are registered; no combinational path from input to output except cmd_ready (which depends only on state).
- Address and data for channels 1..N_CH-1 are constant 0.

Decomposition:
- Package bambu_slave_pkg:
  - op encoding (OP_WRITE, OP_READ, OP_RUN).
  - FSM state typedef.
  - SIZE_BYTE=8.
  - channel slice helper constants.
- One sub-module, bambu_sat_counter: CNT_W saturating counter with clear/enable. It is instantiated twice, once for timeout and once for run cycles.

Test Plan:
- Write addr=0x05, data=0xA7; responder asserts DataRdy 1 cycle after we -> S_we_ram=2'b01 for exactly 1 cycle, S_addr_ram[6:0]=5, S_data_ram_size[3:0]=8, rsp_valid with rsp_err=0.
- Read addr=0x05; responder returns 0xA7 with DataRdy 2 cycles after oe -> rsp_rdata=0xA7, rsp_err=0, S_oe_ram pulse 1 cycle.
- Run with done_port asserted 10 cycles after the start_port cycle -> single-cycle start_port, rsp_cycles=11.
- Read with DataRdy never asserted, TIMEOUT=64 -> rsp_err=1, rsp_rdata=0, rsp_valid 64 cycles after the ISSUE cycle; next command is still accepted normally.
- cmd_op=3 -> immediate rsp_err=1, no strobes; then hold rsp_ready=0 for 5 cycles -> response stable, cmd_ready=0.
- Assert reset during WAIT and during RUN -> all outputs 0 in the same cycle (asynchronous), no response emitted, FSM back in IDLE.
